// File: rtl/onehot_scan_decoder_pkg.sv
// Shared definitions for the one-hot scan decoder.
//   ST_*        : FSM state encodings
//   sel2onehot  : index -> one-hot vector, sized for the widest supported
//                 select; callers truncate to their own OUT_W
package onehot_scan_decoder_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 1 << MAX_SEL_W;

  function automatic logic [MAX_OUT_W-1:0] sel2onehot(input logic [MAX_SEL_W-1:0] s);
    logic [MAX_OUT_W-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_if.sv
// Control/output bundle of the one-hot scan decoder.
//   en, mode, sel, sel_valid, dwell : controller -> decoder
//   D, idx, wrap                    : decoder -> consumer (all registered)
// master = the side driving controls, slave = the decoder itself.
interface onehot_scan_decoder_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = 1 << SEL_W;

  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic               sel_valid;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   D;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  modport master (output en, mode, sel, sel_valid, dwell,
                  input  D, idx, wrap);
  modport slave  (input  en, mode, sel, sel_valid, dwell,
                  output D, idx, wrap);
endinterface

// File: rtl/onehot_scan_decoder_dwell_timer.sv
// Dwell counter for scan mode.
//   clk, rst : clock, async active-high reset
//   clr      : hold counter at zero (not scanning)
//   dwell    : live compare value; a line is held dwell+1 cycles
//   tick     : high in the cycle cnt == dwell (never while clr)
// If dwell drops below cnt, cnt runs on and wraps through zero naturally
// before the next match.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick
);

  logic [DWELL_W-1:0] cnt;

  assign tick = !clr && (cnt == dwell);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// SEL_W-to-2^SEL_W one-hot decoder with registered output and auto-scan.
//   clk, rst : clock (rising), async active-high reset
//   bus      : slave side of onehot_scan_decoder_if
//              decode mode loads D=onehot(sel) on sel_valid (latency 1);
//              scan mode walks D through all lines, dwell+1 cycles each,
//              pulsing wrap when line 0 follows line OUT_W-1.
// ACTIVE_LOW inverts D only (including its reset value).
module onehot_scan_decoder
  import onehot_scan_decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input logic                   clk,
  input logic                   rst,
  onehot_scan_decoder_if.slave  bus
);

  localparam int               OUT_W = 1 << SEL_W;
  localparam bit               INV   = (ACTIVE_LOW != 0);
  localparam logic [OUT_W-1:0] D_OFF = {OUT_W{INV}};

  logic [1:0]       state;
  logic [OUT_W-1:0] d_q;
  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_inc;
  logic             wrap_q;
  logic             scan_run;
  logic             tick;

  // Output-polarity aware line pattern.
  function automatic logic [OUT_W-1:0] line_of(input logic [SEL_W-1:0] i);
    return OUT_W'(sel2onehot(MAX_SEL_W'(i))) ^ D_OFF;
  endfunction

  assign idx_inc = idx_q + 1'b1;

  // Counter only runs while already settled in SCAN with scan still requested;
  // any mode change or disable clears it so a new dwell starts from zero.
  assign scan_run = bus.en && bus.mode && (state == ST_SCAN);

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (!scan_run),
    .dwell (bus.dwell),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      d_q    <= D_OFF;
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (!bus.en) begin
        state <= ST_IDLE;
        d_q   <= D_OFF;
        idx_q <= '0;
      end else if (!bus.mode) begin
        state <= ST_DECODE;
        if (bus.sel_valid) begin
          idx_q <= bus.sel;
          d_q   <= line_of(bus.sel);
        end else if (state != ST_DECODE) begin
          // fresh entry: nothing active until the first load
          idx_q <= '0;
          d_q   <= D_OFF;
        end
      end else if (state != ST_SCAN) begin
        // scan entry starts at line 0 without a wrap pulse
        state <= ST_SCAN;
        idx_q <= '0;
        d_q   <= line_of('0);
      end else if (tick) begin
        idx_q  <= idx_inc;
        d_q    <= line_of(idx_inc);
        wrap_q <= (idx_q == {SEL_W{1'b1}});
      end
    end
  end

  assign bus.D    = d_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule
